// File: rtl/pipe_pkg.sv
// Shared types for the MIPS pipeline control blocks: register specifier width,
// scoreboard entry layout and hazard-cause encoding.
package pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regWrite;
    logic             memRead;
  } sbEntry_t;

  typedef enum logic [1:0] {
    HZ_NONE        = 2'd0,
    HZ_LOAD_USE    = 2'd1,
    HZ_BR_EX       = 2'd2,
    HZ_BR_MEM_LOAD = 2'd3
  } hazardCause_t;

  // $0 is hardwired, so a write to it can never be a producer.
  function automatic logic slotMatch(input sbEntry_t slot, input logic [REG_W-1:0] r);
    return slot.regWrite && (slot.rd != REG_ZERO) && (slot.rd == r);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-slot destination scoreboard (EX, MEM) shadowing the ID/EX and EX/MEM
// registers, with bubble insertion on hazard stalls and a global hold.
module hazard_scoreboard
  import pipe_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     hold,
  input  logic     bubble,
  input  sbEntry_t idEntry,
  output sbEntry_t exEntry,
  output sbEntry_t memEntry
);

  sbEntry_t slotEx_p1;
  sbEntry_t slotMem_p2;

  // ID -> EX -> MEM shadow stages
  always_ff @(posedge clk) begin
    if (reset) begin
      slotEx_p1  <= '0;
      slotMem_p2 <= '0;
    end else if (!hold) begin
      slotMem_p2 <= slotEx_p1;
      slotEx_p1  <= bubble ? sbEntry_t'('0) : idEntry;
    end
  end

  assign exEntry  = slotEx_p1;
  assign memEntry = slotMem_p2;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use and branch-operand
// stalls, IF/ID flush on taken control transfers, and stall/flush statistics.
module hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             extStall,
  input  logic [REG_W-1:0] registerRsID,
  input  logic [REG_W-1:0] registerRtID,
  input  logic             useRsID,
  input  logic             useRtID,
  input  logic             branchID,
  input  logic             jumpID,
  input  logic             branchTaken,
  input  logic [REG_W-1:0] registerRdID,
  input  logic             regWriteID,
  input  logic             memReadID,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexBubble,
  output logic [REG_W-1:0] registerRdEX,
  output logic [REG_W-1:0] registerRdMEM,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);
  import pipe_pkg::*;

  sbEntry_t     idEntry;
  sbEntry_t     exEntry;
  sbEntry_t     memEntry;
  logic         matchEx;
  logic         matchMem;
  logic         loadUse;
  logic         brEx;
  logic         brMemLoad;
  logic         stall;
  hazardCause_t cause;
  logic [CNT_W-1:0] stallCount_p1;
  logic [CNT_W-1:0] flushCount_p1;

  assign idEntry = '{rd: registerRdID, regWrite: regWriteID, memRead: memReadID};

  hazard_scoreboard uScoreboard (
    .clk      (clk),
    .reset    (reset),
    .hold     (extStall),
    .bubble   (stall),
    .idEntry  (idEntry),
    .exEntry  (exEntry),
    .memEntry (memEntry)
  );

  always_comb begin
    matchEx   = (useRsID && slotMatch(exEntry, registerRsID)) ||
                (useRtID && slotMatch(exEntry, registerRtID));
    matchMem  = (useRsID && slotMatch(memEntry, registerRsID)) ||
                (useRtID && slotMatch(memEntry, registerRtID));
    loadUse   = exEntry.memRead && matchEx;
    brEx      = branchID && matchEx;
    // An ALU result in MEM reaches the ID comparator by forwarding; only a load there stalls.
    brMemLoad = branchID && memEntry.memRead && matchMem;
    stall     = loadUse || brEx || brMemLoad;
  end

  always_comb begin
    cause = HZ_NONE;
    if (loadUse)        cause = HZ_LOAD_USE;
    else if (brEx)      cause = HZ_BR_EX;
    else if (brMemLoad) cause = HZ_BR_MEM_LOAD;
  end

  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    if (reset) begin
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else if (extStall) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
    end else if (stall) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
    end else begin
      ifidFlush = jumpID || (branchID && branchTaken);
    end
  end

  // statistics counters, updated at the edge
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCount_p1 <= '0;
      flushCount_p1 <= '0;
    end else begin
      if (stall && !extStall) stallCount_p1 <= stallCount_p1 + CNT_W'(1);
      if (ifidFlush)          flushCount_p1 <= flushCount_p1 + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (stall == (cause != HZ_NONE));
      assert (!(ifidFlush && idexBubble));
    end
  end

  assign stallCount    = stallCount_p1;
  assign flushCount    = flushCount_p1;
  assign registerRdEX  = exEntry.rd;
  assign registerRdMEM = memEntry.rd;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch operand stalls, flushes,
// external freeze and reset during a stall.
module tb_hazard_ctrl;

  localparam int CNT_W = 32;
  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             extStall;
  logic [REG_W-1:0] registerRsID;
  logic [REG_W-1:0] registerRtID;
  logic             useRsID;
  logic             useRtID;
  logic             branchID;
  logic             jumpID;
  logic             branchTaken;
  logic [REG_W-1:0] registerRdID;
  logic             regWriteID;
  logic             memReadID;
  logic             pcWrite;
  logic             ifidWrite;
  logic             ifidFlush;
  logic             idexBubble;
  logic [REG_W-1:0] registerRdEX;
  logic [REG_W-1:0] registerRdMEM;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .extStall      (extStall),
    .registerRsID  (registerRsID),
    .registerRtID  (registerRtID),
    .useRsID       (useRsID),
    .useRtID       (useRtID),
    .branchID      (branchID),
    .jumpID        (jumpID),
    .branchTaken   (branchTaken),
    .registerRdID  (registerRdID),
    .regWriteID    (regWriteID),
    .memReadID     (memReadID),
    .pcWrite       (pcWrite),
    .ifidWrite     (ifidWrite),
    .ifidFlush     (ifidFlush),
    .idexBubble    (idexBubble),
    .registerRdEX  (registerRdEX),
    .registerRdMEM (registerRdMEM),
    .stallCount    (stallCount),
    .flushCount    (flushCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setId(input logic [4:0] rs, input logic [4:0] rt, input logic uRs,
                       input logic uRt, input logic br, input logic jmp, input logic tkn,
                       input logic [4:0] rd, input logic rw, input logic mr);
    registerRsID = rs;  registerRtID = rt;
    useRsID      = uRs; useRtID      = uRt;
    branchID     = br;  jumpID       = jmp; branchTaken = tkn;
    registerRdID = rd;  regWriteID   = rw;  memReadID   = mr;
  endtask

  task automatic nop();
    setId(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    extStall = 1'b0;
    nop();
    tick();
    settle();
    chk("rst_pcWrite", 32'(pcWrite), 32'd1);
    chk("rst_ifidWrite", 32'(ifidWrite), 32'd1);
    chk("rst_ifidFlush", 32'(ifidFlush), 32'd1);
    chk("rst_idexBubble", 32'(idexBubble), 32'd1);
    tick();
    reset = 1'b0;
    settle();
    chk("rst_stallCount", stallCount, 32'd0);
    chk("rst_flushCount", flushCount, 32'd0);
    chk("rst_rdEX", 32'(registerRdEX), 32'd0);
    chk("idle_ifidFlush", 32'(ifidFlush), 32'd0);

    // Load-use: lw $8 ; add rs=$8
    setId(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
    settle();
    chk("lu_lw_pcWrite", 32'(pcWrite), 32'd1);
    tick();
    setId(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
    settle();
    chk("lu_rdEX", 32'(registerRdEX), 32'd8);
    chk("lu_pcWrite", 32'(pcWrite), 32'd0);
    chk("lu_ifidWrite", 32'(ifidWrite), 32'd0);
    chk("lu_idexBubble", 32'(idexBubble), 32'd1);
    chk("lu_ifidFlush", 32'(ifidFlush), 32'd0);
    tick();
    settle();
    chk("lu_after_pcWrite", 32'(pcWrite), 32'd1);
    chk("lu_after_bubble", 32'(idexBubble), 32'd0);
    chk("lu_rdMEM", 32'(registerRdMEM), 32'd8);
    chk("lu_stallCount", stallCount, 32'd1);
    tick();
    nop();
    tick(); tick();

    // Branch after ALU: add $9 ; beq rt=$9 taken
    setId(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    setId(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    chk("bra_pcWrite", 32'(pcWrite), 32'd0);
    chk("bra_idexBubble", 32'(idexBubble), 32'd1);
    chk("bra_flush_deferred", 32'(ifidFlush), 32'd0);
    tick();
    settle();
    chk("bra_fwd_pcWrite", 32'(pcWrite), 32'd1);
    chk("bra_fwd_bubble", 32'(idexBubble), 32'd0);
    chk("bra_flush", 32'(ifidFlush), 32'd1);
    chk("bra_stallCount", stallCount, 32'd2);
    chk("bra_flushCount0", flushCount, 32'd0);
    tick();
    nop();
    settle();
    chk("bra_flushCount1", flushCount, 32'd1);
    chk("bra_flush_once", 32'(ifidFlush), 32'd0);
    tick(); tick();

    // Branch after load: lw $10 ; beq rs=$10 -> two stalls
    setId(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b1);
    tick();
    setId(5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    chk("brl_stall1", 32'(pcWrite), 32'd0);
    tick();
    settle();
    chk("brl_stall2", 32'(pcWrite), 32'd0);
    chk("brl_stall2_bubble", 32'(idexBubble), 32'd1);
    chk("brl_rdMEM", 32'(registerRdMEM), 32'd10);
    tick();
    settle();
    chk("brl_release", 32'(pcWrite), 32'd1);
    chk("brl_stallCount", stallCount, 32'd4);
    tick();
    nop();
    tick(); tick();

    // Jump flush, then $0 producer followed by dependent branch
    setId(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    chk("jmp_flush", 32'(ifidFlush), 32'd1);
    chk("jmp_pcWrite", 32'(pcWrite), 32'd1);
    tick();
    setId(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    settle();
    chk("jmp_flushCount", flushCount, 32'd2);
    tick();
    setId(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    chk("r0_pcWrite", 32'(pcWrite), 32'd1);
    chk("r0_bubble", 32'(idexBubble), 32'd0);
    tick();
    nop();
    tick(); tick();
    chk("r0_stallCount", stallCount, 32'd4);

    // extStall during a load-use
    setId(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1);
    tick();
    setId(5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0);
    extStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ext_pcWrite", 32'(pcWrite), 32'd0);
      chk("ext_ifidWrite", 32'(ifidWrite), 32'd0);
      chk("ext_bubble", 32'(idexBubble), 32'd0);
      chk("ext_rdEX", 32'(registerRdEX), 32'd12);
      chk("ext_stallCount", stallCount, 32'd4);
      tick();
    end
    extStall = 1'b0;
    settle();
    chk("ext_rel_pcWrite", 32'(pcWrite), 32'd0);
    chk("ext_rel_bubble", 32'(idexBubble), 32'd1);
    tick();
    settle();
    chk("ext_after_pcWrite", 32'(pcWrite), 32'd1);
    chk("ext_after_stallCount", stallCount, 32'd5);
    tick();
    nop();
    tick(); tick();

    // Pending jump held by extStall, re-evaluated on release
    setId(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    extStall = 1'b1;
    settle();
    chk("extj_flush_held", 32'(ifidFlush), 32'd0);
    tick();
    chk("extj_flushCount_hold", flushCount, 32'd2);
    extStall = 1'b0;
    settle();
    chk("extj_flush", 32'(ifidFlush), 32'd1);
    tick();
    chk("extj_flushCount", flushCount, 32'd3);
    nop();
    tick(); tick();

    // Reset asserted during a brEX stall
    setId(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    setId(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    chk("rs_pre_stall", 32'(pcWrite), 32'd0);
    reset = 1'b1;
    settle();
    chk("rs_pcWrite", 32'(pcWrite), 32'd1);
    chk("rs_ifidFlush", 32'(ifidFlush), 32'd1);
    tick();
    reset = 1'b0;
    settle();
    chk("rs_rdEX", 32'(registerRdEX), 32'd0);
    chk("rs_rdMEM", 32'(registerRdMEM), 32'd0);
    chk("rs_unstalled", 32'(pcWrite), 32'd1);
    chk("rs_bubble", 32'(idexBubble), 32'd0);
    chk("rs_stallCount", stallCount, 32'd0);
    chk("rs_flushCount", flushCount, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; sits beside the forwarding unit and decides when forwarding is insufficient.
- Tracks in-flight destination registers (EX, MEM) in an internal scoreboard and stalls the IF/ID stages and bubbles ID/EX when needed.
- Flushes IF/ID on taken branches and jumps, and keeps stall/flush statistics for the testbench and debug.

Parameters:
- CNT_W, 32, width of the stall and flush statistic counters.
- REG_W, 5, register specifier width.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- extStall  in  1  external freeze, e.g. from the memory; holds the whole front end and the scoreboard.
- registerRsID  in  REG_W  rs of the instruction in ID.
- registerRtID  in  REG_W  rt of the instruction in ID.
- useRsID  in  1  ID instruction reads rs.
- useRtID  in  1  ID instruction reads rt.
- branchID  in  1  ID instruction is beq/bne, compared in ID.
- jumpID  in  1  ID instruction is j/jal.
- branchTaken  in  1  ID comparator result; meaningful only when branchID=1.
- registerRdID  in  REG_W  destination of the ID instruction (already muxed rt/rd/31).
- regWriteID  in  1  ID instruction writes a register.
- memReadID  in  1  ID instruction is a load.
- pcWrite  out  1  PC load enable.
- ifidWrite  out  1  IF/ID register enable.
- ifidFlush  out  1  clear IF/ID to a nop.
- idexBubble  out  1  zero the ID/EX control fields.
- registerRdEX  out  REG_W  scoreboard EX destination (debug).
- registerRdMEM  out  REG_W  scoreboard MEM destination (debug).
- stallCount  out  CNT_W  hazard stall cycles since reset.
- flushCount  out  CNT_W  IF/ID flushes since reset.

Behaviour:
- Scoreboard has two slots, EX and MEM. Each slot holds {rd, regWrite, memRead}. On every clk with reset=0 and extStall=0:
  - MEM <= EX.
  - EX <= ID fields, or all-zero when `stall`=1.
- The WB stage is not tracked. The register file is write-before-read, and WB-to-EX is handled by forwarding.
- `match(slot, r)` = slot.regWrite & (slot.rd != 0) & (slot.rd == r), applied to rs if useRsID and to rt if useRtID.
- `loadUse` = EX.memRead & match(EX, rs|rt). This costs 1 stall cycle.
- `brEX` = branchID & match(EX, rs|rt). An ALU producer costs 1 stall; a load producer costs 2 stalls in total.
- `brMEMload` = branchID & MEM.memRead & match(MEM, rs|rt). This costs 1 stall. An ALU result in MEM is forwarded to ID, so it needs no stall.
- `stall` = loadUse | brEX | brMEMload. All control outputs are combinational from the scoreboard registers and the ID inputs, so they act in the same cycle.
- Output mapping, in priority order:
  - reset=1: pcWrite=1, ifidWrite=1, ifidFlush=1, idexBubble=1; scoreboard and counters are cleared at the edge.
  - extStall=1: pcWrite=0, ifidWrite=0, ifidFlush=0, idexBubble=0; scoreboard and counters hold. A pending flush is re-evaluated when extStall drops.
  - stall=1: pcWrite=0, ifidWrite=0, idexBubble=1, ifidFlush=0. branchTaken is ignored while stalled.
  - Otherwise: pcWrite=1, ifidWrite=1, idexBubble=0, ifidFlush = jumpID | (branchID & branchTaken).
- Counters are registered, incremented at the edge, and wrap modulo 2^CNT_W.
  - stallCount increments on `stall` & ~extStall & ~reset.
  - flushCount increments on `ifidFlush` & ~reset.
- Boundary cases:
  - rd=0 never causes a stall.
  - A reset asserted mid-stall clears the scoreboard, and the next cycle runs unstalled.
  - A stall and a taken branch in the same cycle resolve as stall first; the flush happens on the later unstalled cycle.

Decomposition:
- Shared package `pipe_pkg` holds:
  - REG_W and REG_ZERO.
  - The scoreboard entry typedef {rd, regWrite, memRead}.
  - The hazard-cause encoding (NONE, LOAD_USE, BR_EX, BR_MEM_LOAD), exposed internally for assertions.
- One natural sub-module, `hazard_scoreboard`: the 2-slot shift register with bubble insert and hold. Hazard decode and the counters stay in hazard_ctrl.

Test Plan:
- Load-use: `lw $8` in EX (memReadEX=1, rd=8) while ID `add` reads rs=8 → one cycle with pcWrite=0, ifidWrite=0, idexBubble=1; the next cycle is unstalled; stallCount=1.
- Branch after ALU: `add $9` in EX, `beq` in ID using rt=9 → exactly 1 stall; the next cycle has no stall and uses forwarding from MEM; stallCount=1.
- Branch after load: `lw $10` in EX, `beq` using rs=10 → 2 consecutive stall cycles (brEX, then brMEMload); stallCount=2.
- Taken branch and jump: branchID=1, branchTaken=1, no hazard → ifidFlush=1 for exactly 1 cycle; jumpID=1 → ifidFlush=1; flushCount=2. Writes to rd=0 followed by a dependent branch on $0 → no stall.
- extStall during a load-use: extStall=1 for 3 cycles → all enables are 0, idexBubble=0, the scoreboard holds and stallCount holds. After release, exactly 1 hazard stall occurs.
- Reset mid-stall: assert reset during brEX → the next cycle has the scoreboard zeroed, outputs pcWrite=1, stallCount=0 and flushCount=0.
